mux_4_x_1: RTL and testbench
============================

MUX_4_X_1 -- requirements
Module: mux_4_x_1

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each data lane.
REQ-002 Port clk  input  1: single clock; all sequential logic on rising edge.
REQ-003 Port rst  input  1: reset, asynchronous, active-high.
REQ-004 Port a  input  4*WIDTH: four packed data lanes; lane i = a[i*WIDTH +: WIDTH], lane 0 in the LSBs.
REQ-005 Port s  input  2: lane select, unsigned.
REQ-006 Port en  input  1: load enable for the registered output.
REQ-007 Port y  output  WIDTH: combinational selected lane.
REQ-008 Port y_q  output  WIDTH: registered copy of y.
REQ-009 Port y_q_valid  output  1: y_q holds a value captured since the last reset.

Function
REQ-010 y SHALL equal lane s: s=0 gives lane 0, s=1 gives lane 1, s=2 gives lane 2, s=3 gives lane 3.
REQ-011 y SHALL be purely combinational, with zero latency from a and s, and SHALL be independent of clk, rst and en.
REQ-012 On each rising clk edge with en=1 and rst=0, y_q SHALL load y and y_q_valid SHALL set to 1.
REQ-013 On each rising clk edge with en=0, y_q and y_q_valid SHALL hold their values.
REQ-014 Latency from a/s change to y_q SHALL be one clk edge while en=1.
REQ-015 s bits that are X/Z are out of scope; no X-recovery logic is required.
REQ-016 Lanes SHALL pass through unmodified; no arithmetic, no width change.
REQ-017 A change to a or s in the same cycle as an en edge SHALL be sampled with its pre-edge settled value.

Reset
REQ-018 While rst=1, y_q SHALL be 0 and y_q_valid SHALL be 0, asynchronously, regardless of clk and en.
REQ-019 After rst deasserts, the first rising edge with en=1 SHALL load y_q normally.
REQ-020 Reset SHALL NOT affect y, which keeps tracking a and s during reset.
REQ-021 Reset asserted mid-operation SHALL clear y_q within the same cycle without waiting for a clock edge.

Structure
REQ-022 The select tree SHALL be built from three instances of sub-module mux_2x1 (WIDTH-parameterised, sel=0 passes in0).
REQ-023 First stage: s[0] SHALL select lane0/lane1 and lane2/lane3.
REQ-024 Second stage: s[1] SHALL select between the two first-stage results.
REQ-025 The lane count (4) and select width (2) constants SHALL live in a shared package mux_pkg; WIDTH stays a module parameter.

Verification
(Vectors use WIDTH=1; a is written as a[3:0].)
REQ-026 a=4'b1101, s=2'b10 -> y=1; after an en=1 edge, y_q=1 and y_q_valid=1.
REQ-027 a=4'b1011, s=2'b00 -> y=1; a=4'b1100, s=2'b11 -> y=1.
REQ-028 a=4'b0110, s=2'b01 -> y=1; a=4'b0101, s=2'b10 -> y=1; a=4'b1011, s=2'b10 -> y=0.
REQ-029 Walking-one a over 4'b0001..4'b1000 against all 4 s values -> y=1 only when s equals the one-hot index; y_q follows one edge later.
REQ-030 With en=0, change a/s for 3 edges -> y_q is unchanged while y updates immediately.
REQ-031 Assert rst between clock edges while y_q=1 -> y_q=0 and y_q_valid=0 immediately, and y is unaffected.

Source files
------------

// File: rtl/mux_pkg.sv
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared lane-count and select-width constants for mux_4_x_1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

  localparam int unsigned c_num_lanes = 4;
  localparam int unsigned c_sel_width = 2;

  typedef logic [c_sel_width-1:0] sel_t;

endpackage : mux_pkg

`default_nettype wire

// File: rtl/mux_2x1.sv
// ============================================================================
//  Module      : mux_2x1
//  Description : WIDTH-bit two-input selector; i_sel=0 passes i_in0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_2x1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_in0,
  input  logic [WIDTH-1:0] i_in1,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_out
);

  assign o_out = i_sel ? i_in1 : i_in0;

endmodule : mux_2x1

`default_nettype wire

// File: rtl/mux_4_x_1.sv
// ============================================================================
//  Module      : mux_4_x_1
//  Description : Four-lane selector built as a two-level mux_2x1 tree, with a
//                combinational output and an enable-loaded registered copy.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_4_x_1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [c_num_lanes*WIDTH-1:0] a,
  input  sel_t                         s,
  input  logic                         en,
  output logic [WIDTH-1:0]             y,
  output logic [WIDTH-1:0]             y_q,
  output logic                         y_q_valid
);

  logic [WIDTH-1:0] w_lane [c_num_lanes];
  logic [WIDTH-1:0] w_stage1_lo;
  logic [WIDTH-1:0] w_stage1_hi;
  logic [WIDTH-1:0] w_sel_out;
  logic [WIDTH-1:0] r_y_q;
  logic             r_y_q_valid;

  generate
    for (genvar g = 0; g < c_num_lanes; g++) begin : g_lanes
      assign w_lane[g] = a[g*WIDTH +: WIDTH];
    end
  endgenerate

  // First stage picks within each lane pair on s[0]; second stage picks the pair on s[1].
  mux_2x1 #(.WIDTH(WIDTH)) u_mux_stage1_lo (
    .i_in0 (w_lane[0]),
    .i_in1 (w_lane[1]),
    .i_sel (s[0]),
    .o_out (w_stage1_lo)
  );

  mux_2x1 #(.WIDTH(WIDTH)) u_mux_stage1_hi (
    .i_in0 (w_lane[2]),
    .i_in1 (w_lane[3]),
    .i_sel (s[0]),
    .o_out (w_stage1_hi)
  );

  mux_2x1 #(.WIDTH(WIDTH)) u_mux_stage2 (
    .i_in0 (w_stage1_lo),
    .i_in1 (w_stage1_hi),
    .i_sel (s[1]),
    .o_out (w_sel_out)
  );

  assign y = w_sel_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_q       <= '0;
      r_y_q_valid <= 1'b0;
    end else if (en) begin
      r_y_q       <= w_sel_out;
      r_y_q_valid <= 1'b1;
    end
  end

  assign y_q       = r_y_q;
  assign y_q_valid = r_y_q_valid;

endmodule : mux_4_x_1

`default_nettype wire

// File: tb/tb_mux_4_x_1.sv
// ============================================================================
//  Module      : tb_mux_4_x_1
//  Description : Directed-vector self-checking bench for mux_4_x_1 (WIDTH=1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_4_x_1;

  localparam int WIDTH = 1;

  logic             clk;
  logic             rst;
  logic [3:0]       a;
  logic [1:0]       s;
  logic             en;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             y_q_valid;

  int n_tests;
  int n_fail;

  mux_4_x_1 #(.WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .s         (s),
    .en        (en),
    .y         (y),
    .y_q       (y_q),
    .y_q_valid (y_q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Drive a/s at the falling edge and check y shortly after.
  task automatic drive_and_check_y(input string tag, input logic [3:0] av,
                                   input logic [1:0] sv, input logic exp_y);
    @(negedge clk);
    a = av;
    s = sv;
    #1 check(tag, {3'b0, y}, {3'b0, exp_y});
  endtask

  task automatic edge_and_check_q(input string tag, input logic exp_q, input logic exp_v);
    @(posedge clk);
    #1;
    check({tag, "_yq"}, {3'b0, y_q}, {3'b0, exp_q});
    check({tag, "_vld"}, {3'b0, y_q_valid}, {3'b0, exp_v});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    en  = 1'b0;
    a   = 4'b0000;
    s   = 2'b00;

    // Reset state, and y tracks inputs during reset.
    #2;
    check("rst_yq",  {3'b0, y_q}, 4'b0000);
    check("rst_vld", {3'b0, y_q_valid}, 4'b0000);
    drive_and_check_y("rst_y_track", 4'b0100, 2'b10, 1'b1);
    en = 1'b1;
    edge_and_check_q("rst_hold", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

    // Basic vectors.
    drive_and_check_y("v1101_s2", 4'b1101, 2'b10, 1'b1);
    en = 1'b1;
    edge_and_check_q("v1101_s2", 1'b1, 1'b1);
    drive_and_check_y("v1011_s0", 4'b1011, 2'b00, 1'b1);
    drive_and_check_y("v1100_s3", 4'b1100, 2'b11, 1'b1);
    drive_and_check_y("v0110_s1", 4'b0110, 2'b01, 1'b1);
    drive_and_check_y("v0101_s2", 4'b0101, 2'b10, 1'b1);
    drive_and_check_y("v1011_s2", 4'b1011, 2'b10, 1'b0);
    edge_and_check_q("v1011_s2", 1'b0, 1'b1);

    // Walking one against every select value.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [3:0] av;
        logic       ev;
        av = 4'b0001 << i;
        ev = (i == j);
        drive_and_check_y($sformatf("walk_a%0d_s%0d", i, j), av, j[1:0], ev);
        edge_and_check_q($sformatf("walk_a%0d_s%0d", i, j), ev, 1'b1);
      end
    end

    // Hold with en=0: y follows, y_q stays at 1.
    drive_and_check_y("hold_load", 4'b1000, 2'b11, 1'b1);
    edge_and_check_q("hold_load", 1'b1, 1'b1);
    en = 1'b0;
    drive_and_check_y("hold_e1", 4'b0111, 2'b11, 1'b0);
    edge_and_check_q("hold_e1", 1'b1, 1'b1);
    drive_and_check_y("hold_e2", 4'b1110, 2'b00, 1'b0);
    edge_and_check_q("hold_e2", 1'b1, 1'b1);
    drive_and_check_y("hold_e3", 4'b0101, 2'b01, 1'b0);
    edge_and_check_q("hold_e3", 1'b1, 1'b1);

    // Mid-cycle asynchronous reset.
    drive_and_check_y("arst_pre", 4'b0010, 2'b01, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("arst_yq",  {3'b0, y_q}, 4'b0000);
    check("arst_vld", {3'b0, y_q_valid}, 4'b0000);
    check("arst_y",   {3'b0, y}, 4'b0001);
    en = 1'b1;
    edge_and_check_q("arst_hold", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    edge_and_check_q("post_rst_load", 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mux_4_x_1

`default_nettype wire
